// File: rtl/uart_pkg.sv
// Shared UART definitions for uart_tx and uart_rx: FSM state encoding, data width, default oversampling.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  // 3-bit encoding; the unused codes 6 and 7 are recovered to S_IDLE by the receiver.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4,
    S_PARITY = 3'd5
  } uart_state_e;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic uart_even_par(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous level; resets to 1 (idle UART line).
// Latency: STAGES i_clk cycles from i_d to o_q.
// Backpressure: none, samples every i_clk.
//
// Ports:
//   i_clk  - clock
//   i_rst  - asynchronous active-high reset, forces every stage to 1
//   i_d    - asynchronous input
//   o_q    - synchronized output
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_d};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits MSB-first, 1 stop; optional even parity (macro UART_RX_PARITY_EN).
// Latency: o_valid rises 1 i_clk after the i_rxpulse tick that samples the stop bit.
// Backpressure: valid/ready output holds one byte; a byte completing while it is still held is dropped with o_overrun.
//
// Ports:
//   i_clk        - system clock
//   i_rst        - asynchronous active-high reset (internal w_intrst)
//   i_rxpulse    - one-cycle tick at OVERSAMPLE x baud
//   i_rxd        - asynchronous serial line, idle high
//   o_data       - received byte, stable while o_valid && !i_ready
//   o_valid      - o_data holds an unconsumed byte
//   i_ready      - downstream accepts the byte
//   o_frame_err  - 1-cycle pulse: stop bit sampled 0
//   o_overrun    - 1-cycle pulse: completed byte dropped, output still occupied
//   o_parity_err - (UART_RX_PARITY_EN only) 1-cycle pulse with the deliver cycle on parity mismatch
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rxpulse,
  input  logic                      i_rxd,
  output logic [UART_DATA_BITS-1:0] o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                      o_parity_err,
`endif
  output logic                      o_overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  logic w_intrst;
  logic rxd_s;

  assign w_intrst = i_rst;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (w_intrst),
    .i_d   (i_rxd),
    .o_q   (rxd_s)
  );

  uart_state_e               state_q,    state_d;
  logic [CW-1:0]             tick_cnt_q, tick_cnt_d;
  logic [2:0]                bit_cnt_q,  bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q,    shift_d;
  logic [UART_DATA_BITS-1:0] data_q,     data_d;
  logic                      valid_q,    valid_d;
  logic                      ferr_q,     ferr_d;
  logic                      ovr_q,      ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                      par_q,      par_d;
  logic                      perr_q,     perr_d;
`endif
  logic                      dlv;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    perr_d     = 1'b0;
`endif
    dlv        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_rxpulse && !rxd_s) begin
          tick_cnt_d = '0;
          state_d    = S_START;
        end
      end

      S_START: begin
        if (i_rxpulse) begin
          if (tick_cnt_q == HALF_M1) begin
            tick_cnt_d = '0;
            if (!rxd_s) begin
              // Start bit confirmed at its centre; later samples land mid-bit.
              bit_cnt_d = 3'd7;
              state_d   = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (i_rxpulse) begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            shift_d    = {shift_q[UART_DATA_BITS-2:0], rxd_s};
            if (bit_cnt_q == 3'd0) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (i_rxpulse) begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            par_d      = rxd_s;
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
`endif

      S_STOP: begin
        if (i_rxpulse) begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            if (rxd_s) begin
              dlv     = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      // A line held low after a bad stop bit must not be taken as a new start bit.
      S_BREAK: begin
        if (rxd_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        tick_cnt_d = '0;
      end
    endcase

    // Output slot: a transfer empties it, a deliver in the same cycle refills it without a gap.
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
    if (dlv) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      perr_d = par_q ^ uart_even_par(shift_q);
`endif
    end
  end

  always_ff @(posedge i_clk or posedge w_intrst) begin
    if (w_intrst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver on the far end of the UART link; consumes the line driven by the team's uart_tx (`o_txd`).
- Frame format: 1 start bit (0), 8 data bits MSB-first, 1 stop bit (1). Line idles high.
- Samples the line on an oversampling tick and delivers each byte on a valid/ready output stream.
- The stream feeds the downstream byte consumer (RX FIFO or command parser).

Parameters:
- OVERSAMPLE, 16, number of `i_rxpulse` ticks per bit period. Even, ≥4.
- SYNC_STAGES, 2, flip-flop stages in the `i_rxd` metastability synchronizer. ≥2.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset input; drives internal reset w_intrst
- i_rxpulse  in  1  one-`i_clk`-wide tick at OVERSAMPLE × baud
- i_rxd  in  1  asynchronous serial line in; idle high
- o_data  out  8  received byte
- o_valid  out  1  `o_data` holds an unconsumed byte
- i_ready  in  1  downstream accepts the byte
- o_frame_err  out  1  1-cycle pulse: stop bit sampled 0
- o_overrun  out  1  1-cycle pulse: completed byte dropped because output was still occupied
- Interface decision: reset w_intrst, asynchronous, active-high; clock i_clk.

Behaviour:
- Reset (w_intrst high, asynchronous):
  - Outputs: `o_data`=0x00, `o_valid`=0, `o_frame_err`=0, `o_overrun`=0.
  - Internal: state=S_IDLE, tick counter=0, bit counter=0, shift register=0, synchronizer flops=1.
  - Reset mid-frame aborts the frame. No partial byte is ever presented.
- `rxd_s` is `i_rxd` after SYNC_STAGES flops, all clocked every `i_clk`. Every decision below uses `rxd_s` only.
- Tick counter: width $clog2(OVERSAMPLE). It advances only on `i_rxpulse`.
- State machine (encoding 3 bits):
  - S_IDLE:
    - On `i_rxpulse` with `rxd_s`==0: tick counter ← 0, go to S_START.
  - S_START:
    - Count ticks on `i_rxpulse`.
    - On the tick where the counter reaches OVERSAMPLE/2−1 (mid start bit), sample `rxd_s`.
    - Sample 0: tick counter ← 0, bit counter ← 7, go to S_DATA.
    - Sample 1: glitch; return to S_IDLE with no flag.
  - S_DATA:
    - On the tick where the counter reaches OVERSAMPLE−1 (mid bit), shift register ← {shift[6:0], `rxd_s`} (MSB-first) and the counter wraps to 0.
    - Bit counter 7→0. After the sample taken with bit counter == 0, go to S_STOP.
  - S_STOP:
    - On counter == OVERSAMPLE−1, sample `rxd_s`.
    - Sample 1: deliver (below), go to S_IDLE.
    - Sample 0: `o_frame_err` pulses for 1 cycle, byte discarded, go to S_BREAK.
  - S_BREAK:
    - Wait until `rxd_s`==1, then go to S_IDLE. This prevents retriggering on a held-low line.
  - Illegal state encodings → S_IDLE.
- Deliver, in the cycle after the stop-sample tick:
  - If `o_valid`==0, or `i_ready`==1 in the deliver cycle: `o_data` ← shift, `o_valid` ← 1.
  - Otherwise: `o_overrun` pulses for 1 cycle; the new byte is dropped and the old `o_data` is kept.
- Output handshake:
  - A transfer occurs when `o_valid` && `i_ready`.
  - `o_valid` falls the next cycle unless a deliver occurs in the same cycle; in that case `o_valid` stays 1 with the new data.
  - `o_data` is stable while `o_valid`=1 and `i_ready`=0.
  - `i_ready` with `o_valid`=0 is ignored.
- Latency: `o_valid` rises 1 `i_clk` after the `i_rxpulse` that samples the stop bit.
- `i_rxpulse` absent: the FSM holds its state indefinitely. Only `rxd_s` and the output handshake keep moving.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - An even-parity bit is expected between D0 and the stop bit, adding state S_PARITY (1 bit period).
  - A parity mismatch pulses port `o_parity_err` (1 bit) together with the deliver cycle. The byte is still delivered.
- Undefined: no S_PARITY state, no `o_parity_err` port, 10-bit frame.

Decomposition:
- Shared package uart_pkg:
  - State localparams S_IDLE..S_PARITY.
  - UART_DATA_BITS=8.
  - Default OVERSAMPLE.
  - Used by both uart_tx and uart_rx.
- One sub-module: uart_sync, the SYNC_STAGES-deep reset-to-1 synchronizer. Instantiated on `i_rxd`.

Test Plan:
- Frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1), OVERSAMPLE=16, `i_ready`=1 → `o_data`=0xA5, `o_valid` high 1 cycle, no error pulses.
- Glitch: line low for 4 ticks, then high → no `o_valid`, FSM back in S_IDLE, next frame 0x3C received correctly.
- Stop bit forced 0 on frame 0xFF → `o_frame_err` 1-cycle pulse, no `o_valid`; line held low 3 bit times then released; next frame 0x12 received.
- Two frames 0x11 then 0x22 with `i_ready`=0 → `o_data`=0x11 held, `o_overrun` pulse at second stop; raise `i_ready` → 0x11 transferred, `o_valid` falls.
- Back-to-back: `i_ready` asserted in the same cycle a new byte delivers → `o_valid` stays 1, `o_data` changes 0x11→0x22 with no gap.
- Assert `i_rst` mid S_DATA of 0x5A → all outputs 0 immediately; after release a full 0xC3 frame is received and no 0x5A fragment appears.
